vram_fetch: RTL and testbench

VRAM_FETCH -- requirements
Module: vram_fetch

---
 rtl/vram_fetch_pkg.sv | 21 ++
 rtl/vram_fetch_if.sv | 27 ++
 rtl/vram_fetch_pair_fifo.sv | 48 ++++
 rtl/vram_fetch.sv | 136 +++++++++++++
 tb/tb_vram_fetch.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_fetch_pkg.sv
// Shared definitions for the video-fetch blocks: fetch FSM encoding and
// output pair FIFO geometry.
package vram_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHAR  = 3'd1,
    ATTR  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int PAIR_W     = 16;

  // Occupancy of the 2-entry pair FIFO recovered from its flags.
  function automatic logic [1:0] fifo_level(input logic full, input logic empty);
    return full ? 2'd2 : (empty ? 2'd0 : 2'd1);
  endfunction

endpackage

// File: rtl/vram_fetch_if.sv
// Bundle of the fetch control, VRAM read port and char/attr stream signals.
interface vram_fetch_if #(parameter int AW = 14);

  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] count;
  logic          busy;
  logic          done;
  logic          ram_ce;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_do;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_char;
  logic [7:0]    out_attr;

  modport slave (
    input  start, base, count, ram_do, out_ready,
    output busy, done, ram_ce, ram_a, out_valid, out_char, out_attr
  );

  modport master (
    output start, base, count, ram_do, out_ready,
    input  busy, done, ram_ce, ram_a, out_valid, out_char, out_attr
  );

endinterface

// File: rtl/vram_fetch_pair_fifo.sv
// Two-entry FIFO holding completed char/attr pairs; head is always visible
// on dout. Simultaneous push and pop both take effect.
module pair_fifo
  import vram_fetch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [PAIR_W-1:0] din,
  output logic [PAIR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PAIR_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == (PW+1)'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is cleared too, so the head reads zero straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/vram_fetch.sv
// Text-mode cell fetcher: reads char/attr byte pairs from VRAM and streams
// them through a 2-entry FIFO with back-pressure.
module vram_fetch
  import vram_fetch_pkg::*;
#(
  parameter int AW = 14
) (
  input logic        clock,
  input logic        reset,
  vram_fetch_if.slave bus
);

  fetch_state_t      state, state_nx;
  logic [AW-1:0]     ptr_q;
  logic [AW-1:0]     rem_q;
  logic              char_vld_p1;
  logic              attr_vld_p1;
  logic              done_q;
  logic [7:0]        char_p1;

  logic              ce;
  logic              ptr_inc;
  logic              rem_dec;
  logic              load;
  logic              done_nx;
  logic              room;
  logic [2:0]        occ_next;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PAIR_W-1:0] fifo_dout;

  assign fifo_push = attr_vld_p1;
  assign fifo_pop  = bus.out_valid && bus.out_ready;

  // Slots claimed after this edge: FIFO content plus the pair whose attr
  // read is being issued now.
  assign occ_next = 3'(fifo_level(fifo_full, fifo_empty)) + 3'(fifo_push)
                  + 3'(state == ATTR) - 3'(fifo_pop);
  assign room     = (occ_next < 3'(FIFO_DEPTH));

  always_comb begin
    state_nx = state;
    ce       = 1'b0;
    ptr_inc  = 1'b0;
    rem_dec  = 1'b0;
    load     = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            load     = 1'b1;
            state_nx = CHAR;
          end else begin
            done_nx  = 1'b1;
          end
        end
      end
      CHAR: begin
        ce       = 1'b1;
        ptr_inc  = 1'b1;
        state_nx = ATTR;
      end
      ATTR: begin
        ce      = 1'b1;
        ptr_inc = 1'b1;
        rem_dec = 1'b1;
        if (rem_q == AW'(1)) state_nx = DRAIN;
        else if (room)       state_nx = CHAR;
        else                 state_nx = HOLD;
      end
      HOLD: begin
        if (room) state_nx = CHAR;
      end
      DRAIN: begin
        if (fifo_empty && !attr_vld_p1) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      char_vld_p1 <= 1'b0;
      attr_vld_p1 <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      char_vld_p1 <= (state == CHAR);
      attr_vld_p1 <= (state == ATTR);
      done_q      <= done_nx;
      if (load) begin
        ptr_q <= bus.base;
        rem_q <= bus.count;
      end else begin
        if (ptr_inc) ptr_q <= ptr_q + AW'(1);
        if (rem_dec) rem_q <= rem_q - AW'(1);
      end
    end
  end

  // p1: read data returns one cycle after the strobe; hold the char byte
  // until its attr arrives, then push the pair.
  always_ff @(posedge clock) begin
    if (char_vld_p1) char_p1 <= bus.ram_do;
  end

  pair_fifo u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({char_p1, bus.ram_do}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_char  = fifo_dout[15:8];
  assign bus.out_attr  = fifo_dout[7:0];
  assign bus.ram_ce    = ce;
  assign bus.ram_a     = ce ? ptr_q : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_vram_fetch.sv
// Scoreboard bench for vram_fetch: runs are expanded into expected char/attr
// pairs from a byte-array VRAM image; a monitor pops and compares on handshake.
module tb_vram_fetch;

  localparam int AW    = 14;
  localparam int MEMSZ = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b1;

  vram_fetch_if #(.AW(AW)) bus ();

  vram_fetch #(.AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]    mem [MEMSZ];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  logic [15:0]   exp_q [$];
  logic [AW-1:0] ce_addr_q [$];
  int            ce_cyc_q [$];
  int            hs_cyc_q [$];
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic [15:0]   prev_pl = '0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // VRAM: synchronous read, data one cycle after the strobe.
  always @(posedge clock) begin
    if (bus.ram_ce) bus.ram_do <= mem[bus.ram_a];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_logs();
    ce_addr_q.delete();
    ce_cyc_q.delete();
    hs_cyc_q.delete();
  endtask

  // Issue a start and expand the run into the pairs the reader must see.
  task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] c);
    logic [AW-1:0] a;
    logic [AW-1:0] a1;
    bus.start = 1'b1;
    bus.base  = b;
    bus.count = c;
    for (int i = 0; i < int'(c); i++) begin
      a  = b + AW'(2 * i);
      a1 = a + AW'(1);
      exp_q.push_back({mem[a], mem[a1]});
    end
    cycles(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input bit rnd);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      cycles(1);
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    n_checks++;
    if (done_cnt == d0) begin
      n_errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", budget);
    end
    bus.out_ready = 1'b1;
  endtask

  // Monitor: samples just after the falling edge.
  always begin
    @(negedge clock);
    #1;
    if (reset) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (bus.ram_ce) begin
        ce_addr_q.push_back(bus.ram_a);
        ce_cyc_q.push_back(cyc);
      end
      if (bus.done) done_cnt++;
      if (prev_v && !prev_r) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_payload", 32'({bus.out_char, bus.out_attr}), 32'(prev_pl));
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pair: got %02h/%02h required no pair", bus.out_char, bus.out_attr);
        end else begin
          check("pair", 32'({bus.out_char, bus.out_attr}), 32'(exp_q.pop_front()));
        end
      end
      prev_v  = bus.out_valid;
      prev_r  = bus.out_ready;
      prev_pl = {bus.out_char, bus.out_attr};
    end
  end

  initial begin
    int d0;
    int n;
    logic [AW-1:0] wrap_exp [4];
    logic [AW-1:0] b;

    bus.start     = 1'b0;
    bus.base      = '0;
    bus.count     = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);

    reset = 1'b1;
    cycles(3);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_ce",    32'(bus.ram_ce),    32'd0);
    check("rst_addr",  32'(bus.ram_a),     32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_char",  32'(bus.out_char),  32'd0);
    check("rst_attr",  32'(bus.out_attr),  32'd0);
    reset = 1'b0;
    cycles(2);

    // Basic three-cell run from a known image.
    mem[14'h0100] = 8'h41; mem[14'h0101] = 8'h07;
    mem[14'h0102] = 8'h42; mem[14'h0103] = 8'h70;
    mem[14'h0104] = 8'h43; mem[14'h0105] = 8'h0F;
    bus.out_ready = 1'b1;
    clear_logs();
    d0 = done_cnt;
    start_run(14'h0100, 14'd3);
    wait_done(d0, 100, 1'b0);
    cycles(3);
    check("t1_done_once", 32'(done_cnt - d0), 32'd1);
    check("t1_busy_low",  32'(bus.busy), 32'd0);
    check("t1_drained",   32'(exp_q.size()), 32'd0);
    check("t1_pairs",     32'(hs_cyc_q.size()), 32'd3);
    if (hs_cyc_q.size() == 3 && ce_cyc_q.size() > 0) begin
      check("t1_latency", 32'(hs_cyc_q[0] - ce_cyc_q[0]), 32'd3);
      check("t1_gap1",    32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd2);
      check("t1_gap2",    32'(hs_cyc_q[2] - hs_cyc_q[1]), 32'd2);
    end

    // Address wrap at the top of VRAM.
    clear_logs();
    d0 = done_cnt;
    start_run(14'h3FFE, 14'd2);
    wait_done(d0, 100, 1'b0);
    cycles(2);
    wrap_exp[0] = 14'h3FFE; wrap_exp[1] = 14'h3FFF;
    wrap_exp[2] = 14'h0000; wrap_exp[3] = 14'h0001;
    check("t2_reads", 32'(ce_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ce_addr_q.size()) check("t2_addr", 32'(ce_addr_q[i]), 32'(wrap_exp[i]));
    end

    // Back-pressure: only two pairs may be fetched while the reader stalls.
    bus.out_ready = 1'b0;
    clear_logs();
    d0 = done_cnt;
    b  = AW'($urandom);
    start_run(b, 14'd4);
    cycles(20);
    check("t3_stall_reads", 32'(ce_addr_q.size()), 32'd4);
    check("t3_hold_ce",     32'(bus.ram_ce), 32'd0);
    check("t3_valid",       32'(bus.out_valid), 32'd1);
    check("t3_busy",        32'(bus.busy), 32'd1);
    bus.out_ready = 1'b1;
    wait_done(d0, 100, 1'b0);
    cycles(2);
    check("t3_pairs",   32'(hs_cyc_q.size()), 32'd4);
    check("t3_reads",   32'(ce_addr_q.size()), 32'd8);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Empty run.
    clear_logs();
    d0 = done_cnt;
    start_run(14'h0055, 14'd0);
    check("t4_done_next", 32'(bus.done), 32'd1);
    check("t4_busy",      32'(bus.busy), 32'd0);
    cycles(1);
    check("t4_done_pulse", 32'(bus.done), 32'd0);
    cycles(3);
    check("t4_no_reads", 32'(ce_addr_q.size()), 32'd0);
    check("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Reset in the middle of an eight-cell run.
    clear_logs();
    b  = AW'($urandom);
    start_run(b, 14'd8);
    n = 0;
    while (hs_cyc_q.size() < 2 && n < 100) begin
      cycles(1);
      n++;
    end
    check("t5_reached", 32'(hs_cyc_q.size() >= 2), 32'd1);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check("t5_busy",  32'(bus.busy),      32'd0);
    check("t5_ce",    32'(bus.ram_ce),    32'd0);
    check("t5_addr",  32'(bus.ram_a),     32'd0);
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    check("t5_char",  32'(bus.out_char),  32'd0);
    check("t5_attr",  32'(bus.out_attr),  32'd0);
    exp_q.delete();
    cycles(2);
    reset = 1'b0;
    cycles(4);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_idle_valid", 32'(bus.out_valid), 32'd0);
    clear_logs();
    d0 = done_cnt;
    start_run(14'h0000, 14'd1);
    wait_done(d0, 100, 1'b0);
    cycles(2);
    check("t5_rerun_pairs", 32'(hs_cyc_q.size()), 32'd1);
    check("t5_rerun_drain", 32'(exp_q.size()), 32'd0);

    // A start while busy is ignored.
    clear_logs();
    d0 = done_cnt;
    b  = AW'($urandom);
    start_run(b, 14'd3);
    cycles(2);
    bus.start = 1'b1;
    bus.base  = b + AW'(100);
    bus.count = 14'd5;
    cycles(1);
    bus.start = 1'b0;
    wait_done(d0, 100, 1'b0);
    cycles(20);
    check("t6_done_once", 32'(done_cnt - d0), 32'd1);
    check("t6_pairs",     32'(hs_cyc_q.size()), 32'd3);
    check("t6_drained",   32'(exp_q.size()), 32'd0);
    check("t6_busy",      32'(bus.busy), 32'd0);

    // Random runs with a randomly stalling reader.
    for (int r = 0; r < 12; r++) begin
      clear_logs();
      d0 = done_cnt;
      b  = AW'($urandom);
      start_run(b, AW'($urandom_range(1, 6)));
      wait_done(d0, 400, 1'b1);
      cycles(3);
      check("rnd_drained", 32'(exp_q.size()), 32'd0);
      check("rnd_done",    32'(done_cnt - d0), 32'd1);
      check("rnd_busy",    32'(bus.busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
